// File: rtl/fetch_icache_responder_pkg.sv
// Shared definitions for the lane-0 instruction-cache fetch responder.
//   ICacheRespState_t  : responder control states
//   ICACHE_LINE_WORDS  : 32-bit words per cache line
//   ICACHE_OFFSET_W    : byte-offset bits within a line
package fetch_icache_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP_ERR
    } ICacheRespState_t;

    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned ICACHE_OFFSET_W   = 4;

endpackage

// File: rtl/fetch_icache_responder_if.sv
// FetchOrder_Interface: four-lane fetch bus between the fetch stage (master)
// and an instruction responder (slave).
//   taskValid[3:0]  master -> slave  per-lane request valid
//   address         master -> slave  fetch byte address
//   taskReady[3:0]  slave -> master  per-lane response strobe
//   taskError[3:0]  slave -> master  per-lane error, valid with taskReady
//   readBus[3:0]    slave -> master  per-lane 32-bit instruction word
interface FetchOrder_Interface #(
    parameter int unsigned ADDR_W = 40
);
    logic [3:0]        taskValid;
    logic [ADDR_W-1:0] address;
    logic [3:0]        taskReady;
    logic [3:0]        taskError;
    logic [3:0][31:0]  readBus;

    modport master (output taskValid, address, input taskReady, taskError, readBus);
    modport slave  (input taskValid, address, output taskReady, taskError, readBus);
endinterface

// File: rtl/fetch_icache_responder_line_store.sv
// icache_line_store: direct-mapped tag/valid/data flop arrays.
//   clk_i, rst_ni     clock, async active-low reset (valid bits only)
//   rd_index_i        combinational read index -> rd_valid_o/rd_tag_o/rd_data_o
//   wr_index_i        line selected for tag and data writes
//   tag_wr_i, tag_i   tag write
//   wr_en_i, wr_word_i, wr_data_i   single-word data write
//   valid_wr_i, valid_val_i         set/clear valid of wr_index_i
//   clear_all_i       invalidate every line (wins over valid_wr_i)
module icache_line_store
    import fetch_icache_responder_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 30
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [INDEX_W-1:0]                   rd_index_i,
    output logic                                 rd_valid_o,
    output logic [TAG_W-1:0]                     rd_tag_o,
    output logic [ICACHE_LINE_WORDS-1:0][31:0]   rd_data_o,
    input  logic [INDEX_W-1:0]                   wr_index_i,
    input  logic                                 tag_wr_i,
    input  logic [TAG_W-1:0]                     tag_i,
    input  logic                                 wr_en_i,
    input  logic [1:0]                           wr_word_i,
    input  logic [31:0]                          wr_data_i,
    input  logic                                 valid_wr_i,
    input  logic                                 valid_val_i,
    input  logic                                 clear_all_i
);
    localparam int unsigned LINES = 1 << INDEX_W;

    logic [LINES-1:0]                         valid_q;
    logic [TAG_W-1:0]                         tag_q  [LINES];
    logic [ICACHE_LINE_WORDS-1:0][31:0]       data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (valid_wr_i) begin
            valid_q[wr_index_i] <= valid_val_i;
        end
    end

    // Tag/data carry no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (tag_wr_i) begin
            tag_q[wr_index_i] <= tag_i;
        end
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/fetch_icache_responder.sv
// fetch_icache_responder: slave end of FetchOrder_Interface serving lane-0
// fetches from a direct-mapped instruction cache, refilling misses over a
// word-wide memory read bus. Lanes 1..3 are never serviced.
//   clk, rst (async active-low), flush (invalidate all lines)
//   fetchFace            fetch bus (slave modport)
//   mem_req/mem_addr     word read request, held until mem_ack
//   mem_ack/mem_rdata/mem_err   beat completion
//   miss_count           refills started (wraps)
module fetch_icache_responder
    import fetch_icache_responder_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned ADDR_W  = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    FetchOrder_Interface.slave   fetchFace,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_err,
    output logic [31:0]          miss_count
);
    localparam int unsigned TAG_W = ADDR_W - ICACHE_OFFSET_W - INDEX_W;
    localparam int unsigned TAG_LSB = ICACHE_OFFSET_W + INDEX_W;

    ICacheRespState_t   state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
    logic               poison_q, poison_d;
    logic [31:0]        miss_count_q, miss_count_d;

    logic               req_v;
    logic [ADDR_W-1:0]  req_addr;
    logic [1:0]         req_word;
    logic [INDEX_W-1:0] req_index, lat_index, store_index;
    logic [TAG_W-1:0]   req_tag, lat_tag;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [ICACHE_LINE_WORDS-1:0][31:0] rd_data;
    logic               hit;

    logic               tag_wr, wr_en, valid_wr, valid_val;
    logic               ready0, err0;
    logic [31:0]        rdata0;

    assign req_v     = fetchFace.taskValid[0];
    assign req_addr  = fetchFace.address;
    assign req_word  = req_addr[3:2];
    assign req_index = req_addr[TAG_LSB-1:ICACHE_OFFSET_W];
    assign req_tag   = req_addr[ADDR_W-1:TAG_LSB];
    assign lat_index = lat_addr_q[TAG_LSB-1:ICACHE_OFFSET_W];
    assign lat_tag   = lat_addr_q[ADDR_W-1:TAG_LSB];

    // Miss start writes the requested line; refill beats write the latched one.
    assign store_index = (state_q == IDLE) ? req_index : lat_index;
    assign hit         = rd_valid && (rd_tag == req_tag);

    icache_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rd_index_i  (req_index),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_index_i  (store_index),
        .tag_wr_i    (tag_wr),
        .tag_i       (req_tag),
        .wr_en_i     (wr_en),
        .wr_word_i   (beat_q),
        .wr_data_i   (mem_rdata),
        .valid_wr_i  (valid_wr),
        .valid_val_i (valid_val),
        .clear_all_i (flush)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            lat_addr_q   <= '0;
            poison_q     <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            lat_addr_q   <= lat_addr_d;
            poison_q     <= poison_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        lat_addr_d   = lat_addr_q;
        poison_d     = poison_q;
        miss_count_d = miss_count_q;
        ready0       = 1'b0;
        err0         = 1'b0;
        rdata0       = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        tag_wr       = 1'b0;
        wr_en        = 1'b0;
        valid_wr     = 1'b0;
        valid_val    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_v) begin
                    if (req_addr[1:0] != 2'b00) begin
                        ready0 = 1'b1;
                        err0   = 1'b1;
                    end else if (!flush) begin
                        if (hit) begin
                            ready0 = 1'b1;
                            rdata0 = rd_data[req_word];
                        end else begin
                            // Line is invalidated up front so no partial hit is possible.
                            lat_addr_d   = req_addr;
                            beat_d       = '0;
                            miss_count_d = miss_count_q + 32'd1;
                            tag_wr       = 1'b1;
                            valid_wr     = 1'b1;
                            valid_val    = 1'b0;
                            state_d      = REFILL;
                        end
                    end
                end
            end

            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {lat_tag, lat_index, beat_q, 2'b00};
                poison_d = poison_q | flush;
                if (mem_ack) begin
                    if (mem_err) begin
                        valid_wr = 1'b1;
                        poison_d = 1'b0;
                        state_d  = RESP_ERR;
                    end else begin
                        wr_en = 1'b1;
                        if (beat_q == 2'd3) begin
                            // A flush on this very edge also poisons the line.
                            valid_wr  = 1'b1;
                            valid_val = !(poison_q || flush);
                            poison_d  = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            beat_d = beat_q + 2'd1;
                        end
                    end
                end
            end

            RESP_ERR: begin
                if (req_v && (req_addr == lat_addr_q)) begin
                    ready0 = 1'b1;
                    err0   = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetchFace.taskReady  = {3'b000, ready0};
        fetchFace.taskError  = {3'b000, err0};
        fetchFace.readBus    = '0;
        fetchFace.readBus[0] = rdata0;
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_fetch_icache_responder.sv
module tb_fetch_icache_responder;

    localparam int unsigned INDEX_W = 6;
    localparam int unsigned ADDR_W  = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_err = 1'b0;
    logic [31:0]       miss_count;

    FetchOrder_Interface #(.ADDR_W(ADDR_W)) ff ();

    fetch_icache_responder #(
        .INDEX_W (INDEX_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fetchFace  (ff),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       sbq[$];
    bit          m_valid [64];
    logic [29:0] m_tag   [64];
    int unsigned m_misses = 0;
    logic [31:0] ovr [logic [39:0]];

    logic [39:0] exp_line = '0;
    int unsigned exp_beat = 0;
    int unsigned beats_seen = 0;
    bit          err_armed = 0;
    logic [39:0] err_addr = '0;
    int unsigned wait_cnt = 0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [39:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a[31:0] * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
    endtask

    // ---------------- memory responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_err = 1'b0;
            if (rst && mem_req) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    check("mem_addr", 64'(mem_addr), 64'(exp_line + 40'((exp_beat % 4) * 4)));
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    if (err_armed && mem_addr == err_addr) begin
                        mem_err   = 1'b1;
                        err_armed = 0;
                    end
                    exp_beat++;
                    beats_seen++;
                    wait_cnt = $urandom_range(0, 2);
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst && ff.taskReady[0]) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ready", 64'(ff.taskReady[0]), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("task_error", 64'(ff.taskError[0]), 64'(e.err));
                    if (!e.err) check("read_data", 64'(ff.readBus[0]), 64'(e.data));
                    check("upper_lanes", 64'(|{ff.taskReady[3:1], ff.taskError[3:1],
                                               ff.readBus[3], ff.readBus[2], ff.readBus[1]}), 64'd0);
                end
            end
        end
    end

    // ---------------- master ----------------
    // Called at posedge+1; returns at posedge+1.
    task automatic fetch(input logic [39:0] a, input int drop_after = -1,
                         input int flush_at = -1, input int err_beat = -1);
        resp_t       e;
        int          kind;
        int unsigned idx;
        logic [29:0] tg;
        int unsigned exp_beats;
        int          waited;
        bit          got;
        bit          flushed;
        idx = a[9:4];
        tg  = a[39:10];
        exp_beats = 0;
        waited = 0;
        got = 0;
        flushed = 0;
        beats_seen = 0;
        e.err = 0;
        e.data = mem_word(a);
        if (a[1:0] != 2'b00) begin
            kind = 0;
            e.err = 1;
        end else if (m_valid[idx] && m_tag[idx] == tg) begin
            kind = 1;
        end else begin
            kind = 2;
            exp_line = {a[39:4], 4'h0};
            exp_beat = 0;
            if (err_beat >= 0) begin
                err_armed = 1;
                err_addr  = exp_line + 40'(err_beat * 4);
                e.err     = 1;
                exp_beats = err_beat + 1;
                m_valid[idx] = 0;
                m_misses++;
            end else if (flush_at >= 0) begin
                // flushed refill completes invalid, then the held request refills again
                model_clear_all();
                exp_beats = 8;
                m_misses += 2;
                m_valid[idx] = 1;
                m_tag[idx] = tg;
            end else begin
                exp_beats = 4;
                m_misses++;
                m_valid[idx] = 1;
                m_tag[idx] = tg;
            end
        end
        if (drop_after < 0) sbq.push_back(e);

        ff.address   = a;
        ff.taskValid = 4'b0001;
        while (!got) begin
            @(negedge clk);
            if (ff.taskReady[0]) begin
                got = 1;
            end else begin
                if (flush_at >= 0 && !flushed && beats_seen == flush_at) begin
                    flushed = 1;
                    flush = 1'b1;
                    @(posedge clk);
                    #1 flush = 1'b0;
                end
                if (drop_after >= 0 && beats_seen >= drop_after) break;
                waited++;
                if (waited > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_timeout: addr %0h no taskReady after %0d cycles", a, waited);
                    break;
                end
            end
        end

        if (drop_after >= 0) begin
            ff.taskValid = 4'b0000;
            waited = 0;
            @(posedge clk);
            #1;
            while (mem_req && waited < 300) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check("drop_refill_done", 64'(mem_req), 64'd0);
        end else begin
            @(posedge clk);
            #1 ff.taskValid = 4'b0000;
            if (kind != 2) check("zero_latency", 64'(waited), 64'd0);
        end
        check("beats", 64'(beats_seen), 64'(exp_beats));
        check("miss_count", 64'(miss_count), 64'(m_misses));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [39:0] a;
        int          r;
        int          eb;
        int          waited;
        ff.taskValid = 4'b0000;
        ff.address   = '0;
        model_clear_all();
        ovr[40'h100] = 32'h11;
        ovr[40'h104] = 32'h22;
        ovr[40'h108] = 32'h33;
        ovr[40'h10C] = 32'h44;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'({ff.taskReady, ff.taskError}), 64'd0);
        check("rst_readbus", 64'(|{ff.readBus[0], ff.readBus[1], ff.readBus[2], ff.readBus[3]}), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // directed sequence
        fetch(40'h104);                    // cold miss -> 0x22
        fetch(40'h108);                    // hit 0x33
        fetch(40'h10C);                    // hit 0x44
        fetch(40'h102);                    // misaligned
        fetch(40'h200, -1, -1, 2);         // error on beat 2
        fetch(40'h200);                    // refill again
        fetch(40'h300, -1, 1, -1);         // flush during beat 1
        fetch(40'h104);                    // flushed -> miss
        fetch(40'h400, 1, -1, -1);         // drop after beat 0
        fetch(40'h40C);                    // hit with beat-3 data

        // randomized traffic over a few conflicting tags and a handful of lines
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                flush = 1'b1;
                model_clear_all();
                @(posedge clk);
                #1 flush = 1'b0;
            end else begin
                a = '0;
                a[39:10] = 30'($urandom_range(0, 3)) * 30'h0123_4567;
                a[6:4]   = 3'($urandom_range(0, 7));
                a[3:2]   = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
                fetch(a, -1, -1, eb);
            end
        end

        // reset in the middle of a refill
        exp_line = 40'h500;
        exp_beat = 0;
        ff.address = 40'h500;
        ff.taskValid = 4'b0001;
        waited = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("refill_started", 64'(mem_req), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check("rst_mid_miss_count", 64'(miss_count), 64'd0);
        ff.taskValid = 4'b0000;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
